// File: rtl/ex_dsram_req_pkg.sv
// Shared encodings for the EX-stage data-SRAM request issuer: access sizes,
// FSM state codes and the default counter width.
package ex_dsram_req_pkg;

    localparam int CNT_W_DEF = 2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FLSH = 2'd2
    } dsram_state_e;

    // The illegal size code 3 is issued as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/dsram_strb_gen.sv
// Combinational byte-strobe generation and store-data lane replication
// for a size/address pair; loads produce an all-zero strobe.
module dsram_strb_gen
    import ex_dsram_req_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    logic [3:0] strb_s;

    // Lane selection by access size; halfword addresses are assumed aligned.
    always_comb begin
        strb_s  = 4'b0000;
        wdata_o = wdata_i;
        case (size_i)
            SIZE_BYTE: begin
                strb_s  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                strb_s  = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                strb_s  = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
        if (we_i) begin
            wstrb_o = strb_s;
        end else begin
            wstrb_o = 4'b0000;
        end
    end

endmodule

// File: rtl/ex_dsram_req.sv
// EX-stage data-SRAM request issuer: holds a request stable until addr_ok and
// tracks outstanding / flush-cancelled transactions so MEM sees only live data_ok.
module ex_dsram_req
    import ex_dsram_req_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_op_valid_i,
    input  logic             mem_we_i,
    input  logic [1:0]       mem_size_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    input  logic             mem_allowin_i,
    input  logic             excep_flush_i,
    input  logic             data_sram_addr_ok_i,
    input  logic             data_sram_data_ok_i,
    output logic             data_sram_req_o,
    output logic             data_sram_wr_o,
    output logic [1:0]       data_sram_size_o,
    output logic [3:0]       data_sram_wstrb_o,
    output logic [31:0]      data_sram_addr_o,
    output logic [31:0]      data_sram_wdata_o,
    output logic             ex_mem_done_o,
    output logic             dsram_drop_ok_o,
    output logic [CNT_W-1:0] outst_cnt_o
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    dsram_state_e     state_q;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] cancel_q, cancel_d;
    logic             lat_we_q;
    logic [1:0]       lat_size_q;
    logic [31:0]      lat_addr_q;
    logic [31:0]      lat_wdata_q;

    logic             idle_s, issue_s, req_s, accept_s, dok_s, drop_s;
    logic             we_s;
    logic [1:0]       size_s;
    logic [31:0]      addr_s, wdata_s;
    logic [CNT_W-1:0] cbase_s;

    // Request/handshake decode; a data_ok with nothing outstanding is ignored.
    always_comb begin
        idle_s   = (state_q == ST_IDLE);
        issue_s  = idle_s & mem_op_valid_i & mem_allowin_i & ~excep_flush_i & (outst_q < MAX_C);
        req_s    = issue_s | ~idle_s;
        accept_s = req_s & data_sram_addr_ok_i;
        dok_s    = data_sram_data_ok_i & (outst_q != ZERO_C);
        drop_s   = dok_s & (cancel_q != ZERO_C);
        if (idle_s) begin
            we_s    = mem_we_i;
            size_s  = norm_size(mem_size_i);
            addr_s  = mem_addr_i;
            wdata_s = mem_wdata_i;
        end else begin
            we_s    = lat_we_q;
            size_s  = lat_size_q;
            addr_s  = lat_addr_q;
            wdata_s = lat_wdata_q;
        end
    end

    // Counter next state: a flush makes every accepted txn stale; an accept
    // while flushing or in FLSH belongs to the squashed instruction too.
    always_comb begin
        if (accept_s && !dok_s) begin
            outst_d = outst_q + ONE_C;
        end else if (!accept_s && dok_s) begin
            outst_d = outst_q - ONE_C;
        end else begin
            outst_d = outst_q;
        end
        if (excep_flush_i) begin
            cbase_s  = dok_s ? (outst_q - ONE_C) : outst_q;
            cancel_d = accept_s ? (cbase_s + ONE_C) : cbase_s;
        end else begin
            cbase_s  = drop_s ? (cancel_q - ONE_C) : cancel_q;
            cancel_d = (accept_s && (state_q == ST_FLSH)) ? (cbase_s + ONE_C) : cbase_s;
        end
    end

    // Request FSM, field latch and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            outst_q     <= ZERO_C;
            cancel_q    <= ZERO_C;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_addr_q  <= 32'h0000_0000;
            lat_wdata_q <= 32'h0000_0000;
        end else begin
            outst_q  <= outst_d;
            cancel_q <= cancel_d;
            case (state_q)
                ST_IDLE: begin
                    if (issue_s && !data_sram_addr_ok_i) begin
                        state_q     <= ST_WAIT;
                        lat_we_q    <= mem_we_i;
                        lat_size_q  <= norm_size(mem_size_i);
                        lat_addr_q  <= mem_addr_i;
                        lat_wdata_q <= mem_wdata_i;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (data_sram_addr_ok_i) begin
                        state_q <= ST_IDLE;
                    end else if (excep_flush_i) begin
                        state_q <= ST_FLSH;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_FLSH: begin
                    if (data_sram_addr_ok_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_FLSH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dsram_strb_gen u_strb_gen (
        .we_i      (we_s),
        .size_i    (size_s),
        .addr_lo_i (addr_s[1:0]),
        .wdata_i   (wdata_s),
        .wstrb_o   (data_sram_wstrb_o),
        .wdata_o   (data_sram_wdata_o)
    );

    assign data_sram_req_o  = req_s;
    assign data_sram_wr_o   = we_s;
    assign data_sram_size_o = size_s;
    assign data_sram_addr_o = addr_s;
    assign ex_mem_done_o    = (idle_s & ~mem_op_valid_i)
                            | (accept_s & (state_q != ST_FLSH) & ~excep_flush_i);
    assign dsram_drop_ok_o  = drop_s;
    assign outst_cnt_o      = outst_q;

endmodule

// File: tb/tb_ex_dsram_req.sv
// Directed table-driven bench for ex_dsram_req plus hand sequences for
// reset mid-flush and size normalisation.
module tb_ex_dsram_req;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v, we, al, fl, aok, dok;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic        req_o, wr_o, done_o, drop_o;
    logic [1:0]  size_o, outst_o;
    logic [3:0]  strb_o;
    logic [31:0] addr_o, wdata_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_dsram_req dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_op_valid_i      (v),
        .mem_we_i            (we),
        .mem_size_i          (sz),
        .mem_addr_i          (a),
        .mem_wdata_i         (wd),
        .mem_allowin_i       (al),
        .excep_flush_i       (fl),
        .data_sram_addr_ok_i (aok),
        .data_sram_data_ok_i (dok),
        .data_sram_req_o     (req_o),
        .data_sram_wr_o      (wr_o),
        .data_sram_size_o    (size_o),
        .data_sram_wstrb_o   (strb_o),
        .data_sram_addr_o    (addr_o),
        .data_sram_wdata_o   (wdata_o),
        .ex_mem_done_o       (done_o),
        .dsram_drop_ok_o     (drop_o),
        .outst_cnt_o         (outst_o)
    );

    typedef struct {
        logic v, we; logic [1:0] sz; logic [31:0] a, wd; logic al, fl, aok, dok;
        logic e_req, e_wr; logic [3:0] e_strb; logic [31:0] e_wd, e_addr;
        logic e_done, e_drop; logic [1:0] e_outst;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic iv, iwe, input logic [1:0] isz, input logic [31:0] ia, iwd,
        input logic ial, ifl, iaok, idok,
        input logic rq, wr, input logic [3:0] st, input logic [31:0] ewd, ead,
        input logic dn, dr, input logic [1:0] oc);
        vec_t r;
        r.v = iv; r.we = iwe; r.sz = isz; r.a = ia; r.wd = iwd;
        r.al = ial; r.fl = ifl; r.aok = iaok; r.dok = idok;
        r.e_req = rq; r.e_wr = wr; r.e_strb = st; r.e_wd = ewd; r.e_addr = ead;
        r.e_done = dn; r.e_drop = dr; r.e_outst = oc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic iv, iwe, input logic [1:0] isz, input logic [31:0] ia, iwd,
                          input logic ial, ifl, iaok, idok);
        v = iv; we = iwe; sz = isz; a = ia; wd = iwd; al = ial; fl = ifl; aok = iaok; dok = idok;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req", 32'(req_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd1);
        chk("rst outst", 32'(outst_o), 32'd0);
        chk("rst drop", 32'(drop_o), 32'd0);
        chk("rst strb", 32'(strb_o), 32'd0);
        tick();
        rst_n = 1'b1;

        //          v    we   sz    addr          wdata         al   fl   aok  dok   req  wr   strb     wdata_o       addr_o        done drop outst
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_1000,32'h0000_0000,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_1000,1'b1,1'b0,2'd0));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd0));
        // store byte, addr_ok three cycles late; inputs wander while waiting
        vt.push_back(mk(1'b1,1'b1,2'd0,32'h0000_1003,32'h0000_00AB,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,4'b1000,32'hABAB_ABAB,32'h0000_1003,1'b0,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b1,2'd0,32'h0000_2000,32'h0000_0012,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,4'b1000,32'hABAB_ABAB,32'h0000_1003,1'b0,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b1,2'd0,32'h0000_2000,32'h0000_0012,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,4'b1000,32'hABAB_ABAB,32'h0000_1003,1'b0,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b1,2'd0,32'h0000_2000,32'h0000_0012,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,4'b1000,32'hABAB_ABAB,32'h0000_1003,1'b1,1'b0,2'd0));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd1));
        // two loads fill the window, third is blocked until a slot frees
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0100,32'h0000_0000,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0100,1'b1,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0104,32'h0000_0000,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0104,1'b1,1'b0,2'd1));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0108,32'h0000_0000,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0108,1'b0,1'b0,2'd2));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0108,32'h0000_0000,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0108,1'b0,1'b0,2'd2));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0108,32'h0000_0000,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0108,1'b1,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd2));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd0));
        // outst=1, request waiting, flush -> FLSH, late addr_ok -> both responses dropped
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0200,32'h0000_0000,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0200,1'b1,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0204,32'h0000_0000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0204,1'b0,1'b0,2'd1));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0204,32'h0000_0000,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0204,1'b0,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0204,1'b0,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0204,1'b0,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b1,2'd2));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b1,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd0));
        // flush with an IDLE op: no request
        vt.push_back(mk(1'b1,1'b1,2'd2,32'h0000_0300,32'hDEAD_BEEF,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,4'b1111,32'hDEAD_BEEF,32'h0000_0300,1'b0,1'b0,2'd0));
        // accept and data_ok in the same cycle: count unchanged
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0400,32'h0000_0000,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0400,1'b1,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0404,32'h0000_0000,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0404,1'b1,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd0));
        // halfword store at upper half
        vt.push_back(mk(1'b1,1'b1,2'd1,32'h0000_0502,32'h1234_CDEF,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,4'b1100,32'hCDEF_CDEF,32'h0000_0502,1'b1,1'b0,2'd0));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd1));
        // flush and addr_ok together in WAIT: txn cancelled
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0600,32'h0000_0000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0600,1'b0,1'b0,2'd0));
        vt.push_back(mk(1'b1,1'b0,2'd2,32'h0000_0600,32'h0000_0000,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,4'b0000,32'h0000_0000,32'h0000_0600,1'b0,1'b0,2'd0));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b1,2'd1));
        vt.push_back(mk(1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'b0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,2'd0));

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].v, vt[i].we, vt[i].sz, vt[i].a, vt[i].wd,
                   vt[i].al, vt[i].fl, vt[i].aok, vt[i].dok);
            @(negedge clk);
            chk($sformatf("v%0d req", i),   32'(req_o),   32'(vt[i].e_req));
            chk($sformatf("v%0d wr", i),    32'(wr_o),    32'(vt[i].e_wr));
            chk($sformatf("v%0d wstrb", i), 32'(strb_o),  32'(vt[i].e_strb));
            chk($sformatf("v%0d wdata", i), wdata_o,      vt[i].e_wd);
            chk($sformatf("v%0d addr", i),  addr_o,       vt[i].e_addr);
            chk($sformatf("v%0d done", i),  32'(done_o),  32'(vt[i].e_done));
            chk($sformatf("v%0d drop", i),  32'(drop_o),  32'(vt[i].e_drop));
            chk($sformatf("v%0d outst", i), 32'(outst_o), 32'(vt[i].e_outst));
            tick();
        end

        // reset while a flushed request is still held
        set_in(1'b1, 1'b0, 2'd2, 32'h0000_0700, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 2'd2, 32'h0000_0704, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 2'd2, 32'h0000_0704, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flsh req", 32'(req_o), 32'd1);
        chk("flsh outst", 32'(outst_o), 32'd1);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("rst2 req", 32'(req_o), 32'd0);
        chk("rst2 outst", 32'(outst_o), 32'd0);
        chk("rst2 done", 32'(done_o), 32'd1);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 2'd2, 32'h0000_0800, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst2 cancel cleared", 32'(drop_o), 32'd0);
        chk("rst2 outst live", 32'(outst_o), 32'd1);
        tick();

        // illegal size code issued as a word store
        set_in(1'b1, 1'b1, 2'd3, 32'h0000_0900, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("sz3 size", 32'(size_o), 32'd2);
        chk("sz3 wstrb", 32'(strb_o), 32'hF);
        chk("sz3 wdata", wdata_o, 32'h1122_3344);
        chk("sz3 outst", 32'(outst_o), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("end outst", 32'(outst_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
